// File: rtl/sa_cache_pkg.sv
// sa_cache_pkg: shared geometry, types and helpers for the set-associative
// cache simulator core.
//   Geometry: ADDR_W, OFFSET_W, INDEX_W, TAG_W, WAYS, CNT_W (plus SETS, WAY_W)
//   Types:    way_t (way ID), order_t (per-set LRU order, [0] = MRU), state_t
package sa_cache_pkg;

    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 6;
    localparam int INDEX_W  = 8;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WAYS     = 4;
    localparam int CNT_W    = 20;

    localparam int SETS  = 1 << INDEX_W;
    localparam int WAY_W = $clog2(WAYS);

    typedef logic [WAY_W-1:0] way_t;
    typedef way_t [WAYS-1:0]  order_t;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        UPDATE,
        DONE
    } state_t;

    // Reset replacement order: position p holds way p, so way WAYS-1 is LRU.
    function automatic order_t reset_order();
        order_t o;
        for (int i = 0; i < WAYS; i++) o[i] = way_t'(i);
        return o;
    endfunction

endpackage

// File: rtl/lru_shift_reg.sv
// lru_shift_reg: combinational next-order logic for one cache set.
//   order      in   current LRU order, position 0 = MRU, WAYS-1 = LRU
//   hit        in   access hit in this set
//   hit_way    in   way that hit (ignored on miss)
//   next_order out  order after the access
//   victim     out  way at the LRU position (replaced on a miss)
// The accessed way moves to position 0 and every position in front of its
// old position slides down by one; on a miss the accessed way is the LRU
// victim, so the whole order rotates.
module lru_shift_reg
    import sa_cache_pkg::*;
(
    input  order_t order,
    input  logic   hit,
    input  way_t   hit_way,
    output order_t next_order,
    output way_t   victim
);

    way_t             mru;
    logic [WAY_W-1:0] pos;

    always_comb begin
        victim = order[WAYS-1];
        pos    = WAY_W'(WAYS-1);
        if (hit) begin
            for (int i = 0; i < WAYS; i++) begin
                if (order[i] == hit_way) pos = WAY_W'(i);
            end
        end
        mru = hit ? hit_way : victim;

        next_order    = order;
        next_order[0] = mru;
        for (int i = 1; i < WAYS; i++) begin
            if (WAY_W'(i) <= pos) next_order[i] = order[i-1];
        end
    end

endmodule

// File: rtl/sa_cache_main.sv
// sa_cache_main: trace-driven 4-way set-associative cache simulator core.
// One address per trace_ready rising edge; lookup, tag/LRU update and hit/miss
// counting take four cycles (IDLE -> LOOKUP -> UPDATE -> DONE).
//   clk              in   clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   trace_ready      in   rising level marks a new valid mem_addr
//   mem_addr         in   byte address: tag [31:14], index [13:6]
//   updated          out  one-cycle pulse when an access has been counted
//   cache_hit_count  out  hits since reset
//   cache_miss_count out  misses since reset
// Build option: define SA_CACHE_SAT_CNT_EN to make both counters saturate at
// all-ones instead of wrapping.
module sa_cache_main
    import sa_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trace_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic              updated,
    output logic [CNT_W-1:0]  cache_hit_count,
    output logic [CNT_W-1:0]  cache_miss_count
);

    state_t             state, state_nxt;
    logic               tr_q;
    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] idx_q;
    logic               hit_q;
    way_t               hit_way_q;

    // Tag storage carries no reset: a tag is only ever read behind its valid bit.
    logic [TAG_W-1:0]          tag_arr [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0] valid_arr;
    order_t                    order_arr [SETS];

    logic   accept;
    logic   hit_any;
    way_t   hit_enc;
    order_t next_order;
    way_t   victim;

    // Block offset never affects lookup.
    logic unused_offset;
    assign unused_offset = ^mem_addr[OFFSET_W-1:0];

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
`ifdef SA_CACHE_SAT_CNT_EN
        return (c == '1) ? c : c + 1'b1;
`else
        return c + 1'b1;
`endif
    endfunction

    // Edges that arrive while busy are dropped because tr_q keeps tracking.
    assign accept = (state == IDLE) && trace_ready && !tr_q;

    // Parallel tag compare across the latched set.
    always_comb begin
        hit_any = 1'b0;
        hit_enc = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_arr[idx_q][w] && (tag_arr[idx_q][w] == tag_q)) begin
                hit_any = 1'b1;
                hit_enc = way_t'(w);
            end
        end
    end

    lru_shift_reg u_lru (
        .order      (order_arr[idx_q]),
        .hit        (hit_q),
        .hit_way    (hit_way_q),
        .next_order (next_order),
        .victim     (victim)
    );

    always_comb begin
        state_nxt = state;
        updated   = 1'b0;
        case (state)
            IDLE:    if (accept) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = UPDATE;
            UPDATE:  state_nxt = DONE;
            DONE: begin
                updated   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            tr_q             <= 1'b0;
            tag_q            <= '0;
            idx_q            <= '0;
            hit_q            <= 1'b0;
            hit_way_q        <= '0;
            cache_hit_count  <= '0;
            cache_miss_count <= '0;
            valid_arr        <= '0;
            for (int s = 0; s < SETS; s++) order_arr[s] <= reset_order();
        end else begin
            state <= state_nxt;
            tr_q  <= trace_ready;
            if (accept) begin
                tag_q <= mem_addr[ADDR_W-1 -: TAG_W];
                idx_q <= mem_addr[OFFSET_W +: INDEX_W];
            end
            if (state == LOOKUP) begin
                hit_q     <= hit_any;
                hit_way_q <= hit_enc;
            end
            if (state == UPDATE) begin
                order_arr[idx_q] <= next_order;
                if (hit_q) begin
                    cache_hit_count <= cnt_inc(cache_hit_count);
                end else begin
                    valid_arr[idx_q][victim] <= 1'b1;
                    cache_miss_count         <= cnt_inc(cache_miss_count);
                end
            end
        end
    end

    // State is forced to IDLE during reset, so an aborted access cannot write.
    always_ff @(posedge clk) begin
        if (state == UPDATE && !hit_q) tag_arr[idx_q][victim] <= tag_q;
    end

endmodule

// File: tb/tb_sa_cache_main.sv
// tb_sa_cache_main: self-checking bench for sa_cache_main. Reference model
// keeps, per set, a list of resident tags in most-recently-used order.
module tb_sa_cache_main;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trace_ready = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        updated;
    logic [19:0] cache_hit_count;
    logic [19:0] cache_miss_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sa_cache_main dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .trace_ready      (trace_ready),
        .mem_addr         (mem_addr),
        .updated          (updated),
        .cache_hit_count  (cache_hit_count),
        .cache_miss_count (cache_miss_count)
    );

    // ---------------- reference model ----------------
    logic [17:0] mtag [256][4];
    int          mlen [256];
    int unsigned mh, mm;

    function automatic void model_reset();
        for (int s = 0; s < 256; s++) mlen[s] = 0;
        mh = 0;
        mm = 0;
    endfunction

    function automatic bit model_access(input logic [31:0] a);
        logic [17:0] t;
        int s, pos, n;
        t   = a[31:14];
        s   = int'(a[13:6]);
        pos = -1;
        for (int i = 0; i < mlen[s]; i++) if (mtag[s][i] == t) pos = i;
        if (pos >= 0) begin
            for (int i = pos; i > 0; i--) mtag[s][i] = mtag[s][i-1];
            mtag[s][0] = t;
            mh++;
            return 1'b1;
        end
        n = (mlen[s] < 4) ? mlen[s] : 3;
        for (int i = n; i > 0; i--) mtag[s][i] = mtag[s][i-1];
        mtag[s][0] = t;
        if (mlen[s] < 4) mlen[s]++;
        mm++;
        return 1'b0;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        trace_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // One handshake; checks latency, pulse width and both counters.
    task automatic access(input logic [31:0] a, output bit dut_hit);
        logic [19:0] h0;
        int lat;
        @(negedge clk);
        trace_ready = 1'b0;
        mem_addr    = a;
        @(negedge clk);
        trace_ready = 1'b1;          // accepted at the next rising edge
        h0 = cache_hit_count;
        void'(model_access(a));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!updated && lat < 10);
        chk("updated latency", lat, 3);
        chk("hit count", {12'b0, cache_hit_count}, mh & 32'hFFFFF);
        chk("miss count", {12'b0, cache_miss_count}, mm & 32'hFFFFF);
        dut_hit = (cache_hit_count != h0);
        @(negedge clk);
        chk("updated single pulse", {31'b0, updated}, 0);
        trace_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          hit;
    } vec_t;

    vec_t seq8 [8];
    vec_t alt8 [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit h;
        int pulses;
        logic [19:0] sum0;

        seq8[0] = '{32'h0000_0000, 1'b0};
        seq8[1] = '{32'h0000_4000, 1'b0};
        seq8[2] = '{32'h0000_8000, 1'b0};
        seq8[3] = '{32'h0000_C000, 1'b0};
        seq8[4] = '{32'h0000_0000, 1'b1};
        seq8[5] = '{32'h0001_0000, 1'b0};
        seq8[6] = '{32'h0000_4000, 1'b0};
        seq8[7] = '{32'h0000_0000, 1'b1};
        for (int i = 0; i < 8; i++) begin
            alt8[i].addr = (i % 2 == 0) ? 32'h0000_0040 : 32'h0000_0000;
            alt8[i].hit  = (i >= 2);
        end

        // reset state
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset updated", {31'b0, updated}, 0);
        chk("reset hit count", {12'b0, cache_hit_count}, 0);
        chk("reset miss count", {12'b0, cache_miss_count}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // first access misses, same block hits
        access(32'h0000_0000, h);
        chk("0x0 first", {31'b0, h}, 0);
        access(32'h0000_0004, h);
        chk("0x4 same block", {31'b0, h}, 1);

        // set-0 eviction sequence
        do_reset();
        for (int i = 0; i < 8; i++) begin
            access(seq8[i].addr, h);
            chk($sformatf("seq8[%0d] hit", i), {31'b0, h}, {31'b0, seq8[i].hit});
        end
        chk("seq8 hits", {12'b0, cache_hit_count}, 2);
        chk("seq8 misses", {12'b0, cache_miss_count}, 6);

        // independent sets
        do_reset();
        for (int i = 0; i < 8; i++) begin
            access(alt8[i].addr, h);
            chk($sformatf("alt8[%0d] hit", i), {31'b0, h}, {31'b0, alt8[i].hit});
        end

        // trace_ready held high: one access only
        @(negedge clk);
        trace_ready = 1'b0;
        mem_addr    = 32'h0000_0080;
        sum0        = cache_hit_count + cache_miss_count;
        void'(model_access(32'h0000_0080));
        @(negedge clk);
        trace_ready = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            pulses += int'(updated);
        end
        trace_ready = 1'b0;
        repeat (6) begin
            @(negedge clk);
            pulses += int'(updated);
        end
        chk("held-high pulses", pulses, 1);
        chk("held-high increments", {12'b0, cache_hit_count + cache_miss_count}, {12'b0, sum0 + 20'd1});
        chk("held-high miss count", {12'b0, cache_miss_count}, mm);

        // reset during LOOKUP aborts the access
        @(negedge clk);
        trace_ready = 1'b0;
        mem_addr    = 32'h0000_0000;
        @(negedge clk);
        trace_ready = 1'b1;
        @(negedge clk);              // now in LOOKUP
        rst_n       = 1'b0;
        trace_ready = 1'b0;
        pulses      = 0;
        repeat (2) begin
            @(negedge clk);
            pulses += int'(updated);
        end
        rst_n = 1'b1;
        model_reset();
        repeat (6) begin
            @(negedge clk);
            pulses += int'(updated);
        end
        chk("abort pulses", pulses, 0);
        chk("abort hit count", {12'b0, cache_hit_count}, 0);
        chk("abort miss count", {12'b0, cache_miss_count}, 0);
        access(32'h0000_0000, h);
        chk("after abort 0x0", {31'b0, h}, 0);

        // randomized traffic over a few sets and a small tag pool
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = {14'($urandom_range(0, 5)), 4'b0, 8'($urandom_range(0, 3)), 6'($urandom)};
            access(a, h);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sa_cache_main.md
# sa_cache_main

Trace-driven, 4-way set-associative cache simulator core with a per-set LRU shift register. It accepts one 32-bit memory address per handshake, looks it up, updates tags and replacement order, and maintains running hit and miss counters. It is the top-level compute block of the FPGA cache simulator, fed by a trace source that supplies the next address after each `updated` pulse.

## Interface
- ADDR_W, 32, address width
- OFFSET_W, 6, block offset bits (64 B blocks)
- INDEX_W, 8, set index bits (256 sets)
- WAYS, 4, associativity
- CNT_W, 20, counter width
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- trace_ready  in  1  request strobe; a rising level marks a new valid `mem_addr`
- mem_addr  in  32  byte address; tag = [31:14], index = [13:6], offset ignored
- updated  out  1  one-cycle pulse: access processed, counters current
- cache_hit_count  out  20  total hits since reset
- cache_miss_count  out  20  total misses since reset

## Operation
- FSM states: IDLE, LOOKUP, UPDATE, DONE.
- IDLE: accept when `trace_ready` is 1 and its registered copy is 0 (rising-edge detect); latch `mem_addr`; go to LOOKUP. Rising edges seen outside IDLE are dropped.
- LOOKUP: read the set's tag, valid, and LRU order; compare all ways in parallel; register hit flag and hit way; go to UPDATE.
- UPDATE, on hit at LRU position p: shift positions 0..p-1 down by one; place the hit way at position 0 (MRU); increment the hit counter.
- UPDATE, on miss: victim = way at position WAYS-1 (LRU); write the tag and set valid; shift all positions down; place the victim at MRU; increment the miss counter.
- UPDATE then goes to DONE.
- DONE: `updated` = 1 for exactly one cycle; go to IDLE.
- LRU order is a per-set shift register of WAYS 2-bit way IDs, position 0 = MRU.
- Reset order is [0,1,2,3], so way 3 is LRU.
- Invalid ways always sit at the LRU tail. No separate invalid-way search is needed.
- Line data is not stored; only tags, valid bits, and LRU order.
- Exactly one counter increments per accepted access.

## Timing
- Reset values: state IDLE; `updated` 0; both counters 0; all valid bits 0; every set's LRU order [0,1,2,3]; trace_ready edge register 0.
- Accept at edge N:
  - UPDATE reached at edge N+1.
  - Counters and arrays written at edge N+2; `updated` goes high after edge N+2.
  - `updated` is low again after edge N+3, and the FSM is back in IDLE.
- Throughput: one access per 4 cycles maximum.
- `trace_ready` held high for many cycles produces a single access.
- The source may raise `trace_ready` any time after seeing `updated`.
- Reset asserted mid-access aborts it:
  - No `updated` pulse for the aborted access.
  - No counter change beyond the reset clear.
  - The tag write is lost.
- Counters change only at the UPDATE→DONE edge.

## Configuration
- Macro `SA_CACHE_SAT_CNT_EN`.
- Defined: both counters saturate at 20'hFFFFF and hold there.
- Undefined: both counters wrap modulo 2^20.

## Structure
- Package `sa_cache_pkg` holds:
  - ADDR_W, OFFSET_W, INDEX_W, TAG_W (= ADDR_W-INDEX_W-OFFSET_W), WAYS, CNT_W
  - `state_t` enum
  - way-ID typedef
- Sub-module `lru_shift_reg`: combinational next-order logic for one set.
  - Inputs: current order, hit flag, hit way.
  - Outputs: next order and victim way.
- Tag, valid, and LRU arrays are registers in `sa_cache_main`. Arrays may instead use BRAM provided the 4-cycle latency is kept.

## Test plan
- Reset, then access 0x0000_0000 → miss=1, hit=0; `updated` is a single pulse high 2 edges after the accept edge.
- Then access 0x0000_0004 (same block) → hit=1, miss=1.
- From reset, access 0x0, 0x4000, 0x8000, 0xC000, 0x0, 0x10000, 0x4000, 0x0, all in set 0:
  - Per-access results: M M M M H M M H.
  - Final counts: hit=2, miss=6.
  - 0x10000 evicts 0x4000; the second 0x4000 evicts 0x8000.
- 0x0000_0040 and 0x0000_0000 alternated 4 times → 2 misses, then 6 hits (independent sets).
- `trace_ready` held high 6 cycles → exactly one `updated` pulse; exactly one counter increments.
- `rst_n` pulsed low during LOOKUP → no `updated`; counters 0; next access to 0x0 misses.
